// File: rtl/hps_ext_pkg.sv
// Shared constants for the HPS EXT_BUS mailbox: command offsets, bus bit map
// and the sizing helper used to derive the byte counter width.
package hps_ext_pkg;

  localparam logic [15:0] OFS_GET_STATUS = 16'd0;
  localparam logic [15:0] OFS_SET_CTRL   = 16'd1;
  localparam logic [15:0] OFS_GET_FLAGS  = 16'd2;
  localparam logic [15:0] OFS_PULSE0     = 16'd3;

  localparam int BUS_DOUT_LSB = 0;
  localparam int BUS_DIN_LSB  = 16;
  localparam int BUS_DOUT_EN  = 32;
  localparam int BUS_STROBE   = 33;
  localparam int BUS_ENABLE   = 34;
  localparam int BUS_W        = 36;

  localparam int MAX_PULSE = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hps_ext_bus_if.sv
// EXT_BUS front end: splits the bus, registers dout/dout_en and tracks the
// command latch and byte position of the current transaction.
module hps_ext_bus_if
  import hps_ext_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  inout  wire  [BUS_W-1:0] EXT_BUS,
  input  logic [15:0]      dout_nxt,
  input  logic             in_window,
  output logic [15:0]      din,
  output logic [15:0]      cmd,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             strobe_q,
  output logic             first_q
);

  logic        enable;
  logic [15:0] dout_q;
  logic [15:0] cmd_q;
  logic        dout_en_q;

  assign enable   = EXT_BUS[BUS_ENABLE];
  assign din      = EXT_BUS[BUS_DIN_LSB +: 16];
  assign strobe_q = enable & EXT_BUS[BUS_STROBE];
  assign first_q  = strobe_q && (byte_cnt == '0);
  // On the command byte the code is still on din; afterwards use the latch.
  assign cmd      = first_q ? din : cmd_q;

  assign EXT_BUS[BUS_DOUT_LSB +: 16] = dout_q;
  assign EXT_BUS[BUS_DOUT_EN]        = dout_en_q;

  wire unused_bus = &{1'b0, EXT_BUS[BUS_W-1], EXT_BUS[BUS_DOUT_EN],
                      EXT_BUS[BUS_DOUT_LSB +: 16]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      cmd_q     <= '0;
      byte_cnt  <= '0;
    end else if (!enable) begin
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      cmd_q     <= '0;
      byte_cnt  <= '0;
    end else if (strobe_q) begin
      dout_q <= dout_nxt;
      if (first_q) begin
        cmd_q     <= din;
        dout_en_q <= in_window;
      end
      if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hps_ext_mailbox.sv
// EXT_BUS command slave: status snapshot readback, control block writes and
// request/acknowledge pulse channels with overrun tracking.
module hps_ext_mailbox
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD_BASE     = 16'hF0,
  parameter int          STATUS_WORDS = 10,
  parameter int          CTRL_WORDS   = 2,
  parameter int          NUM_PULSE    = 4,
  parameter int          EVT_W        = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  inout  wire  [BUS_W-1:0]          EXT_BUS,
  input  logic                      evt_toggle,
  input  logic [16*STATUS_WORDS-1:0] status_in,
  output logic [16*CTRL_WORDS-1:0]  ctrl_out,
  output logic                      ctrl_strobe,
  output logic [NUM_PULSE-1:0]      pulse_req,
  output logic [32*NUM_PULSE-1:0]   pulse_arg,
  input  logic [NUM_PULSE-1:0]      pulse_ack
);

  localparam int CNT_W = $clog2(max3(STATUS_WORDS, CTRL_WORDS, 3) + 2);

  logic [15:0]           din, cmd, off, dout_nxt, stage_lo;
  logic [CNT_W-1:0]      byte_cnt;
  logic                  strobe_q, first_q, in_window;
  int                    bidx;
  logic [EVT_W-1:0]      evt_cnt;
  logic                  evt_meta, evt_sync, evt_prev;
  logic [16*STATUS_WORDS-1:0] snap;
  logic [NUM_PULSE-1:0]  overrun, pulse_set, ovr_set, ovr_clr;
  logic [MAX_PULSE-1:0]  flag_pend, flag_ovr;

  hps_ext_bus_if #(.CNT_W(CNT_W)) u_bus (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .EXT_BUS   (EXT_BUS),
    .dout_nxt  (dout_nxt),
    .in_window (in_window),
    .din       (din),
    .cmd       (cmd),
    .byte_cnt  (byte_cnt),
    .strobe_q  (strobe_q),
    .first_q   (first_q)
  );

  assign off       = cmd - CMD_BASE;
  assign in_window = off < (OFS_PULSE0 + 16'(NUM_PULSE));
  assign bidx      = int'(byte_cnt);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dout_nxt  = '0;
    pulse_set = '0;
    ovr_clr   = '0;
    flag_pend = '0;
    flag_ovr  = '0;
    flag_pend[NUM_PULSE-1:0] = pulse_req;
    flag_ovr[NUM_PULSE-1:0]  = overrun;
    if (strobe_q && in_window) begin
      if (first_q) begin
        dout_nxt = 16'(evt_cnt);
      end else if (off == OFS_GET_STATUS) begin
        if (bidx == 1) dout_nxt = status_in[15:0];
        else if (bidx <= STATUS_WORDS) dout_nxt = snap[16*(bidx-1) +: 16];
      end else if (off == OFS_GET_FLAGS) begin
        if (bidx == 1) begin
          dout_nxt = {flag_ovr, flag_pend};
          ovr_clr  = '1;
        end
      end else begin
        for (int i = 0; i < NUM_PULSE; i++)
          if (off == OFS_PULSE0 + 16'(i) && bidx == 2) pulse_set[i] = 1'b1;
      end
    end
  end

  // An ack in the same cycle as a new set consumes the old request.
  assign ovr_set = pulse_set & pulse_req & ~pulse_ack;

  // NOTE: the snapshot is a packed register block, not a memory, so it is
  // reset with everything else and reads as zero after reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      snap        <= '0;
      ctrl_out    <= '0;
      ctrl_strobe <= 1'b0;
      stage_lo    <= '0;
      pulse_arg   <= '0;
      pulse_req   <= '0;
      overrun     <= '0;
    end else begin
      ctrl_strobe <= 1'b0;
      pulse_req   <= (pulse_req & ~pulse_ack) | pulse_set;
      overrun     <= (overrun & ~ovr_clr) | ovr_set;
      if (strobe_q && in_window && !first_q) begin
        if (off == OFS_GET_STATUS && bidx == 1) snap <= status_in;
        if (off == OFS_SET_CTRL && bidx <= CTRL_WORDS) begin
          ctrl_out[16*(bidx-1) +: 16] <= din;
          ctrl_strobe <= (bidx == CTRL_WORDS);
        end
        if (off >= OFS_PULSE0 && bidx == 1) stage_lo <= din;
      end
      for (int i = 0; i < NUM_PULSE; i++)
        if (pulse_set[i]) pulse_arg[32*i +: 32] <= {din, stage_lo};
    end
  end

  // Event counter: two-flop synchroniser, then either-polarity edge detect.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      evt_meta <= 1'b0;
      evt_sync <= 1'b0;
      evt_prev <= 1'b0;
      evt_cnt  <= '0;
    end else begin
      evt_meta <= evt_toggle;
      evt_sync <= evt_meta;
      evt_prev <= evt_sync;
      if (evt_sync ^ evt_prev) evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hps_ext_mailbox.sv
// Directed bench for hps_ext_mailbox: table-driven bus transactions plus
// hand-written sequences for abort, ack/set collision and reset corners.
module tb_hps_ext_mailbox;

  localparam int SW = 10;
  localparam int CW = 2;
  localparam int NP = 4;
  localparam int EW = 8;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic [15:0]       din = '0;
  logic              strobe = 1'b0;
  logic              enable = 1'b0;
  logic              evt_toggle = 1'b0;
  logic [16*SW-1:0]  status_in = '0;
  logic [16*CW-1:0]  ctrl_out;
  logic              ctrl_strobe;
  logic [NP-1:0]     pulse_req;
  logic [NP-1:0]     pulse_ack = '0;
  logic [32*NP-1:0]  pulse_arg;

  wire [35:0] ext_bus;
  assign ext_bus[31:16] = din;
  assign ext_bus[33]    = strobe;
  assign ext_bus[34]    = enable;
  wire [15:0] dout    = ext_bus[15:0];
  wire        dout_en = ext_bus[32];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  hps_ext_mailbox #(
    .CMD_BASE(16'hF0), .STATUS_WORDS(SW), .CTRL_WORDS(CW),
    .NUM_PULSE(NP), .EVT_W(EW)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .EXT_BUS     (ext_bus),
    .evt_toggle  (evt_toggle),
    .status_in   (status_in),
    .ctrl_out    (ctrl_out),
    .ctrl_strobe (ctrl_strobe),
    .pulse_req   (pulse_req),
    .pulse_arg   (pulse_arg),
    .pulse_ack   (pulse_ack)
  );

  typedef struct {
    string       name;
    logic        new_txn;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_den;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic txn_start();
    @(negedge clk_sys);
    enable = 1'b1;
  endtask

  task automatic txn_end();
    @(negedge clk_sys);
    enable = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic xfer(input logic [15:0] d, output logic [15:0] rd, output logic rd_en);
    @(negedge clk_sys);
    din    = d;
    strobe = 1'b1;
    @(negedge clk_sys);
    strobe = 1'b0;
    rd     = dout;
    rd_en  = dout_en;
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      evt_toggle = ~evt_toggle;
      repeat (3) @(negedge clk_sys);
    end
    repeat (4) @(negedge clk_sys);
  endtask

  // Applies the queued vectors; status_in is scrambled after GET_STATUS byte 1.
  task automatic run_table(input logic scramble);
    logic [15:0] rd;
    logic        rd_en;
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].new_txn) begin
        if (i != 0) txn_end();
        txn_start();
      end
      xfer(vt[i].din, rd, rd_en);
      check({vt[i].name, "_dout"}, rd, vt[i].exp_dout);
      check({vt[i].name, "_den"}, rd_en, vt[i].exp_den);
      if (scramble && i == 1) status_in = {SW{16'hDEAD}};
    end
    txn_end();
    vt.delete();
  endtask

  task automatic get_flags(input string name, input logic [15:0] exp);
    logic [15:0] rd;
    logic        rd_en;
    txn_start();
    xfer(16'hF2, rd, rd_en);
    xfer(16'h0000, rd, rd_en);
    check(name, rd, exp);
    txn_end();
  endtask

  task automatic get_word0(input string name, input logic [15:0] exp);
    logic [15:0] rd;
    logic        rd_en;
    txn_start();
    xfer(16'hF0, rd, rd_en);
    check(name, rd, exp);
    txn_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic        rd_en;

    repeat (3) @(negedge clk_sys);
    check("rst_dout", dout, 16'h0);
    check("rst_den", dout_en, 1'b0);
    check("rst_ctrl", ctrl_out, '0);
    check("rst_cstb", ctrl_strobe, 1'b0);
    check("rst_req", pulse_req, '0);
    check("rst_arg", pulse_arg, '0);
    reset = 1'b0;

    // 1: four events, then GET_STATUS with a mid-transaction status change.
    toggles(4);
    for (int k = 0; k < SW; k++) status_in[16*k +: 16] = 16'h1000 + 16'(k);
    vt.push_back('{"gs_cmd", 1'b1, 16'hF0, 16'd4, 1'b1});
    for (int k = 0; k < SW; k++)
      vt.push_back('{$sformatf("gs_w%0d", k), 1'b0, 16'h0, 16'h1000 + 16'(k), 1'b1});
    vt.push_back('{"gs_past0", 1'b0, 16'h0, 16'h0, 1'b1});
    vt.push_back('{"gs_past1", 1'b0, 16'h0, 16'h0, 1'b1});
    run_table(1'b1);

    // 2: SET_CTRL full write, then an aborted write.
    txn_start();
    xfer(16'hF1, rd, rd_en);
    check("sc_cmd", rd, 16'd4);
    xfer(16'hBEEF, rd, rd_en);
    check("sc_stb_w0", ctrl_strobe, 1'b0);
    xfer(16'h0042, rd, rd_en);
    check("sc_stb_w1", ctrl_strobe, 1'b1);
    check("sc_ctrl", ctrl_out, {16'h0042, 16'hBEEF});
    @(negedge clk_sys);
    check("sc_stb_off", ctrl_strobe, 1'b0);
    txn_end();
    txn_start();
    xfer(16'hF1, rd, rd_en);
    xfer(16'h1111, rd, rd_en);
    check("sc_ab_stb", ctrl_strobe, 1'b0);
    txn_end();
    check("sc_ab_stb2", ctrl_strobe, 1'b0);
    check("sc_ab_ctrl", ctrl_out, {16'h0042, 16'h1111});

    // 3: SET_PULSE 2, repeat without ack to create an overrun.
    txn_start();
    xfer(16'hF5, rd, rd_en);
    xfer(16'h5678, rd, rd_en);
    check("sp_stage_req", pulse_req, 4'b0000);
    check("sp_stage_arg", pulse_arg[64 +: 32], 32'h0);
    xfer(16'h1234, rd, rd_en);
    check("sp_req", pulse_req, 4'b0100);
    check("sp_arg", pulse_arg[64 +: 32], 32'h12345678);
    txn_end();
    get_flags("fl_clean", 16'h0004);
    txn_start();
    xfer(16'hF5, rd, rd_en);
    xfer(16'h5678, rd, rd_en);
    xfer(16'h1234, rd, rd_en);
    txn_end();
    get_flags("fl_ovr", 16'h0404);
    get_flags("fl_ovr_clr", 16'h0004);

    // 4: ack collides with byte 2 of a new SET_PULSE 2.
    txn_start();
    xfer(16'hF5, rd, rd_en);
    xfer(16'hAAAA, rd, rd_en);
    @(negedge clk_sys);
    din       = 16'hBBBB;
    strobe    = 1'b1;
    pulse_ack = 4'b0100;
    @(negedge clk_sys);
    strobe    = 1'b0;
    pulse_ack = 4'b0000;
    check("col_req", pulse_req, 4'b0100);
    check("col_arg", pulse_arg[64 +: 32], 32'hBBBBAAAA);
    txn_end();
    get_flags("col_flags", 16'h0004);
    @(negedge clk_sys);
    pulse_ack = 4'b0100;
    @(negedge clk_sys);
    pulse_ack = 4'b0000;
    check("ack_clr", pulse_req, 4'b0000);
    @(negedge clk_sys);
    pulse_ack = 4'b0010;
    @(negedge clk_sys);
    pulse_ack = 4'b0000;
    check("ack_idle", pulse_req, 4'b0000);

    // 5: out-of-window codes, last valid code with an abort before byte 2.
    vt.push_back('{"oow_f7", 1'b1, 16'hF7, 16'h0, 1'b0});
    vt.push_back('{"oow_f7_b1", 1'b0, 16'h1234, 16'h0, 1'b0});
    vt.push_back('{"oow_f7_b2", 1'b0, 16'h5678, 16'h0, 1'b0});
    vt.push_back('{"oow_10", 1'b1, 16'h0010, 16'h0, 1'b0});
    vt.push_back('{"oow_10_b1", 1'b0, 16'hABCD, 16'h0, 1'b0});
    vt.push_back('{"sp3_cmd", 1'b1, 16'hF6, 16'd4, 1'b1});
    vt.push_back('{"sp3_b1", 1'b0, 16'h9999, 16'h0, 1'b1});
    run_table(1'b0);
    check("oow_ctrl", ctrl_out, {16'h0042, 16'h1111});
    check("oow_cstb", ctrl_strobe, 1'b0);
    check("oow_req", pulse_req, 4'b0000);
    check("sp3_abort_arg", pulse_arg[96 +: 32], 32'h0);
    check("oow_arg2", pulse_arg[64 +: 32], 32'hBBBBAAAA);

    // Reset in the middle of GET_STATUS, enable kept high throughout.
    status_in[15:0] = 16'hCAFE;
    txn_start();
    xfer(16'hF0, rd, rd_en);
    xfer(16'h0000, rd, rd_en);
    #2 reset = 1'b1;
    #1;
    check("mr_dout_async", dout, 16'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    check("mr_den", dout_en, 1'b0);
    check("mr_ctrl", ctrl_out, '0);
    check("mr_arg", pulse_arg, '0);
    xfer(16'hF0, rd, rd_en);
    check("mr_cmd_dout", rd, 16'h0);
    check("mr_cmd_den", rd_en, 1'b1);
    xfer(16'h0000, rd, rd_en);
    check("mr_w0", rd, 16'hCAFE);
    txn_end();

    // 6: event counter wrap at 2^EVT_W.
    toggles(255);
    get_word0("evt_255", 16'h00FF);
    toggles(1);
    get_word0("evt_wrap", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
